tffc_counter: RTL and testbench

Parametrised multi-mode register bank generalising the single-bit T flip-flop into a WIDTH-bit block. Each clock it holds, toggles a per-bit mask, counts up or counts down modulo MAX+1. A synchronous parallel load, a cascade terminal-count output and a sticky wrap flag are included. It is the common building block for lab counters, dividers and sequencers in the digital design library.

---
 rtl/tffc_counter.sv | 96 +++++++++
 tb/tb_tffc_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tffc_counter.sv
// tffc_counter: WIDTH-bit multi-mode register bank (hold / toggle-mask /
// count up / count down modulo MAX+1) with synchronous parallel load,
// combinational cascade terminal count and sticky wrap flag.
//
// Build option: define TFFC_SATURATE_EN to clamp at the count limits
// instead of wrapping (ovf still records the attempted wrap).
module tffc_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MAX   = (1 << WIDTH) - 1
) (
   input  logic             clock,
   input  logic             reset,   // async, active low
   input  logic             EN,
   input  logic             load,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] T,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             ovf
);

   typedef enum logic [1:0] {
      M_HOLD   = 2'b00,
      M_TOGGLE = 2'b01,
      M_UP     = 2'b10,
      M_DOWN   = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] L_MAX  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] L_ZERO = '0;
   localparam logic [WIDTH-1:0] L_ONE  = WIDTH'(1);

   // Value taken on a wrap event: wrap-around by default, clamp when saturating.
`ifdef TFFC_SATURATE_EN
   localparam logic [WIDTH-1:0] L_UP_WRAP_Q = L_MAX;
   localparam logic [WIDTH-1:0] L_DN_WRAP_Q = L_ZERO;
`else
   localparam logic [WIDTH-1:0] L_UP_WRAP_Q = L_ZERO;
   localparam logic [WIDTH-1:0] L_DN_WRAP_Q = L_MAX;
`endif

   logic [WIDTH-1:0] r_q;
   logic             r_ovf;
   mode_e            w_mode;
   logic             w_at_top;
   logic             w_at_bot;
   logic             w_up_wrap;
   logic             w_dn_wrap;

   assign w_mode   = mode_e'(mode);
   // Q above MAX (reachable via load or toggle) also counts as "at top".
   assign w_at_top = (r_q >= L_MAX);
   assign w_at_bot = (r_q == L_ZERO);

   assign w_up_wrap = (w_mode == M_UP)   && w_at_top;
   assign w_dn_wrap = (w_mode == M_DOWN) && w_at_bot;

   // Cascade output: independent of reset so a chain sees it at once.
   assign tc  = EN & (w_up_wrap | w_dn_wrap);
   assign Q   = r_q;
   assign ovf = r_ovf;

   // State update: reset > load > EN; ovf is sticky until load or reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_q   <= L_ZERO;
         r_ovf <= 1'b0;
      end else if (load) begin
         r_q   <= D;
         r_ovf <= 1'b0;
      end else if (EN) begin
         case (w_mode)
            M_TOGGLE: r_q <= r_q ^ T;
            M_UP: begin
               if (w_at_top) begin
                  r_q   <= L_UP_WRAP_Q;
                  r_ovf <= 1'b1;
               end else begin
                  r_q <= r_q + L_ONE;
               end
            end
            M_DOWN: begin
               if (w_at_bot) begin
                  r_q   <= L_DN_WRAP_Q;
                  r_ovf <= 1'b1;
               end else begin
                  r_q <= r_q - L_ONE;
               end
            end
            default: r_q <= r_q;
         endcase
      end
   end

endmodule

// File: tb/tb_tffc_counter.sv
// Bench for tffc_counter (WIDTH=4, MAX=9): directed scenarios plus a
// randomized run against an integer-arithmetic reference model.
module tb_tffc_counter;

   localparam int W  = 4;
   localparam int MX = 9;
`ifdef TFFC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         EN    = 1'b0;
   logic         load  = 1'b0;
   logic [1:0]   mode  = 2'b00;
   logic [W-1:0] T     = '0;
   logic [W-1:0] D     = '0;
   logic [W-1:0] Q;
   logic         tc;
   logic         ovf;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_q   = 0;
   bit m_ovf = 1'b0;

   tffc_counter #(.WIDTH(W), .MAX(MX)) dut (
      .clock(clock), .reset(reset), .EN(EN), .load(load), .mode(mode),
      .T(T), .D(D), .Q(Q), .tc(tc), .ovf(ovf)
   );

   always #5 clock = ~clock;

   function automatic bit model_tc();
      return EN && ((mode == 2'd2 && m_q >= MX) || (mode == 2'd3 && m_q == 0));
   endfunction

   // Predict the next state from the current inputs, then take one edge.
   task automatic tick();
      int nq;
      bit no;
      nq = m_q;
      no = m_ovf;
      if (!reset) begin
         nq = 0; no = 1'b0;
      end else if (load) begin
         nq = int'(D); no = 1'b0;
      end else if (EN) begin
         if (mode == 2'd1) nq = (m_q ^ int'(T)) % 16;
         else if (mode == 2'd2) begin
            if (m_q >= MX) begin nq = SAT ? MX : 0; no = 1'b1; end
            else nq = m_q + 1;
         end else if (mode == 2'd3) begin
            if (m_q == 0) begin nq = SAT ? 0 : MX; no = 1'b1; end
            else nq = m_q - 1;
         end
      end
      @(posedge clock);
      #1;
      m_q   = nq;
      m_ovf = no;
   endtask

   task automatic test_reset();
      #2;
      n_tests++;
      if (Q !== 4'd0 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL reset_init: Q=%0d ovf=%b want Q=0 ovf=0", Q, ovf);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      load = 1'b1; D = 4'd5;
      tick();
      load = 1'b0;
      n_tests++;
      if (Q !== 4'd5) begin n_fail++; $display("FAIL reset_load5: Q=%0d want 5", Q); end
      // assert reset mid-cycle, check before the next edge
      #2; reset = 1'b0; mode = 2'b11; EN = 1'b1;
      #1;
      m_q = 0; m_ovf = 1'b0;
      n_tests++;
      if (Q !== 4'd0 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL reset_async: Q=%0d ovf=%b want Q=0 ovf=0", Q, ovf);
      end
      n_tests++;
      if (tc !== 1'b1) begin n_fail++; $display("FAIL reset_tc: tc=%b want 1", tc); end
      EN = 1'b0; mode = 2'b00;
      tick();
      reset = 1'b1;
      tick();
      n_tests++;
      if (Q !== 4'd0 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: Q=%0d ovf=%b want Q=0 ovf=0", Q, ovf);
      end
   endtask

   task automatic test_up_wrap();
      load = 1'b1; D = 4'd7; tick(); load = 1'b0;
      mode = 2'b10; EN = 1'b1;
      tick();
      n_tests++;
      if (Q !== 4'd8 || tc !== 1'b0) begin
         n_fail++; $display("FAIL up_8: Q=%0d tc=%b want Q=8 tc=0", Q, tc);
      end
      tick();
      n_tests++;
      if (Q !== 4'd9 || tc !== 1'b1 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL up_9: Q=%0d tc=%b ovf=%b want Q=9 tc=1 ovf=0", Q, tc, ovf);
      end
      tick();
      n_tests++;
      if (Q !== (SAT ? 4'd9 : 4'd0) || ovf !== 1'b1) begin
         n_fail++; $display("FAIL up_wrap: Q=%0d ovf=%b want Q=%0d ovf=1", Q, ovf, SAT ? 9 : 0);
      end
      tick();
      tick();
      n_tests++;
      if (Q !== (SAT ? 4'd9 : 4'd2) || ovf !== 1'b1) begin
         n_fail++; $display("FAIL up_sticky: Q=%0d ovf=%b want Q=%0d ovf=1", Q, ovf, SAT ? 9 : 2);
      end
      EN = 1'b0;
   endtask

   task automatic test_down_wrap();
      load = 1'b1; D = 4'd1; tick(); load = 1'b0;
      mode = 2'b11; EN = 1'b1;
      tick();
      n_tests++;
      if (Q !== 4'd0 || tc !== 1'b1 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL dn_0: Q=%0d tc=%b ovf=%b want Q=0 tc=1 ovf=0", Q, tc, ovf);
      end
      tick();
      n_tests++;
      if (Q !== (SAT ? 4'd0 : 4'd9) || ovf !== 1'b1) begin
         n_fail++; $display("FAIL dn_wrap: Q=%0d ovf=%b want Q=%0d ovf=1", Q, ovf, SAT ? 0 : 9);
      end
      EN = 1'b0; load = 1'b1; D = 4'd3;
      tick();
      load = 1'b0;
      n_tests++;
      if (Q !== 4'd3 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL dn_reload: Q=%0d ovf=%b want Q=3 ovf=0", Q, ovf);
      end
   endtask

   task automatic test_toggle();
      load = 1'b1; D = 4'b1010; tick(); load = 1'b0;
      mode = 2'b01; EN = 1'b1; T = 4'b0110;
      #1;
      n_tests++;
      if (tc !== 1'b0) begin n_fail++; $display("FAIL tog_tc: tc=%b want 0", tc); end
      tick();
      n_tests++;
      if (Q !== 4'b1100 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL tog_q: Q=%b ovf=%b want Q=1100 ovf=0", Q, ovf);
      end
      EN = 1'b0;
      tick();
      n_tests++;
      if (Q !== 4'b1100 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL tog_hold: Q=%b ovf=%b want Q=1100 ovf=0", Q, ovf);
      end
   endtask

   task automatic test_priority();
      // reach Q=9 with ovf=1 via a down wrap (default build)
      load = 1'b1; D = 4'd0; tick(); load = 1'b0;
      mode = 2'b11; EN = 1'b1; tick();
      n_tests++;
      if (ovf !== 1'b1) begin n_fail++; $display("FAIL prio_pre_ovf: ovf=%b want 1", ovf); end
      load = 1'b1; D = 4'd2; mode = 2'b10; EN = 1'b1;
      #1;
      n_tests++;
      if (tc !== model_tc()) begin n_fail++; $display("FAIL prio_tc: tc=%b want %b", tc, model_tc()); end
      tick();
      load = 1'b0; EN = 1'b0;
      n_tests++;
      if (Q !== 4'd2 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL prio_load: Q=%0d ovf=%b want Q=2 ovf=0", Q, ovf);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         reset = ($urandom_range(0, 39) != 0);
         load  = ($urandom_range(0, 9) == 0);
         EN    = ($urandom_range(0, 3) != 0);
         mode  = 2'($urandom_range(0, 3));
         T     = W'($urandom_range(0, 15));
         D     = W'($urandom_range(0, 15));
         #2;
         if (!reset) begin m_q = 0; m_ovf = 1'b0; end
         n_tests++;
         if (tc !== model_tc()) begin
            n_fail++; $display("FAIL rnd_tc[%0d]: tc=%b want %b", i, tc, model_tc());
         end
         tick();
         n_tests++;
         if (Q !== W'(m_q) || ovf !== m_ovf) begin
            n_fail++;
            $display("FAIL rnd_state[%0d]: Q=%0d ovf=%b want Q=%0d ovf=%b", i, Q, ovf, m_q, m_ovf);
         end
      end
      reset = 1'b1; load = 1'b0; EN = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_toggle();
      test_priority();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
